z80_rotate_shift_unit: RTL



---
 rtl/z80_rotate_shift_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/z80_rotate_shift_unit.sv
// Iterative rotate/shift unit covering the eight CB-prefix rotate/shift ops.
// It performs one bit step per clock and returns Z80-format flags.
module z80_rotate_shift_unit #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned XY_FROM_RESULT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic [7:0]       flags_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [7:0]       flags_out,
  output logic             busy
);

  localparam int unsigned M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               carry_q, carry_d;
  logic [1:0]         xy_q, xy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic [7:0]         flags_q, flags_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
  logic               start_ready_q, start_ready_d;

  logic [WIDTH-1:0]   step_data;
  logic               step_carry;
  logic [WIDTH-1:0]   fin_data;
  logic               fin_carry;
  logic [1:0]         fin_xy;
  logic [7:0]         fin_flags;

  // One single-bit step of the captured operation on the working registers.
  always_comb begin
    step_data  = data_q;
    step_carry = carry_q;
    case (op_q)
      3'd0: begin step_carry = data_q[M]; step_data = {data_q[M-1:0], data_q[M]}; end
      3'd1: begin step_carry = data_q[0]; step_data = {data_q[0], data_q[M:1]}; end
      3'd2: begin step_carry = data_q[M]; step_data = {data_q[M-1:0], carry_q}; end
      3'd3: begin step_carry = data_q[0]; step_data = {carry_q, data_q[M:1]}; end
      3'd4: begin step_carry = data_q[M]; step_data = {data_q[M-1:0], 1'b0}; end
      3'd5: begin step_carry = data_q[0]; step_data = {data_q[M], data_q[M:1]}; end
      3'd6: begin step_carry = data_q[M]; step_data = {data_q[M-1:0], 1'b1}; end
      default: begin step_carry = data_q[0]; step_data = {1'b0, data_q[M:1]}; end
    endcase
  end

  // A zero count spends its single SHIFT cycle as a pass-through, giving uniform latency.
  always_comb begin
    fin_data  = (cnt_q == '0) ? data_q  : step_data;
    fin_carry = (cnt_q == '0) ? carry_q : step_carry;
  end

  // Undocumented flag bits 5/3: from the result or passed through from F.
  generate
    if (XY_FROM_RESULT != 0) begin : g_xy_result
      always_comb fin_xy = {fin_data[5], fin_data[3]};
    end else begin : g_xy_pass
      always_comb fin_xy = xy_q;
    end
  endgenerate

  // Z80 flag byte {S,Z,5,H,3,PV,N,C} derived from the final value.
  always_comb begin
    fin_flags = {fin_data[M], (fin_data == '0), fin_xy[1], 1'b0,
                 fin_xy[0], ~(^fin_data), 1'b0, fin_carry};
  end

  // Next-state, datapath update and registered output values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    carry_d     = carry_q;
    xy_d        = xy_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          op_d    = op;
          cnt_d   = count;
          data_d  = data_in;
          carry_d = carry_in;
          xy_d    = {flags_in[5], flags_in[3]};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q <= CNT_W'(1)) begin
          data_d      = fin_data;
          carry_d     = fin_carry;
          cnt_d       = '0;
          result_d    = fin_data;
          carry_out_d = fin_carry;
          flags_d     = fin_flags;
          state_d     = DONE;
        end else begin
          data_d  = step_data;
          carry_d = step_carry;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    start_ready_d  = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      cnt_q          <= '0;
      data_q         <= '0;
      carry_q        <= 1'b0;
      xy_q           <= '0;
      result_q       <= '0;
      carry_out_q    <= 1'b0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      start_ready_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      carry_q        <= carry_d;
      xy_q           <= xy_d;
      result_q       <= result_d;
      carry_out_q    <= carry_out_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      start_ready_q  <= start_ready_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign carry_out    = carry_out_q;
  assign flags_out    = flags_q;

endmodule
